// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// memory command bit positions, plus the request legality check.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WR
    } lsu_state_e;

    localparam int MEM_WR = 0;
    localparam int MEM_RD = 1;

    // A request is rejected when its size is reserved or it straddles its natural alignment.
    function automatic logic reqIsBad(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = offset[0];
            SZ_W:    bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: extracts and extends load data,
// and merges sub-word store data into the word previously read from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] loadData_o,
    output logic [31:0] storeData_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] laneMask;

    assign shamt = {offset_i, 3'b000};

    always_comb begin
        shifted    = word_i >> shamt;
        loadData_o = word_i;
        laneMask   = 32'hFFFF_FFFF;
        case (size_i)
            SZ_B: begin
                loadData_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
                laneMask   = 32'h0000_00FF << shamt;
            end
            SZ_H: begin
                loadData_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
                laneMask   = 32'h0000_FFFF << shamt;
            end
            default: begin
                loadData_o = word_i;
                laneMask   = 32'hFFFF_FFFF;
            end
        endcase
        storeData_o = (word_i & ~laneMask) | ((wdata_i << shamt) & laneMask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-only data memory: aligns
// accesses, does read-modify-write for sub-word stores and pulses a response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [2:0]        mem_signal_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        reqOffset_q;
    logic [1:0]        reqSize_q;
    logic              reqUnsigned_q;
    logic [DATA_W-1:0] reqWdata_q;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memData_q, memData_d;
    logic              respValid_q, respValid_d;
    logic              respErr_q, respErr_d;
    logic [DATA_W-1:0] respRdata_q, respRdata_d;
    logic [2:0]        memSignal;
    logic              accept;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] storeData;

    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    lsu_lane_align u_align (
        .word_i      (mem_data_i),
        .offset_i    (reqOffset_q),
        .size_i      (reqSize_q),
        .unsigned_i  (reqUnsigned_q),
        .wdata_i     (reqWdata_q),
        .loadData_o  (loadData),
        .storeData_o (storeData)
    );

    // Memory address/data only move when a new access is launched, so they hold while idle.
    always_comb begin
        state_d     = state_q;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        respValid_d = 1'b0;
        respErr_d   = 1'b0;
        respRdata_d = '0;
        memSignal   = 3'b000;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reqIsBad(req_size_i, req_addr_i[1:0])) begin
                        respValid_d = 1'b1;
                        respErr_d   = 1'b1;
                    end else begin
                        memAddr_d = {req_addr_i[ADDR_W-1:2], 2'b00};
                        if (!req_we_i) begin
                            state_d = LOAD;
                        end else if (req_size_i == SZ_W) begin
                            state_d   = WR;
                            memData_d = req_wdata_i;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            LOAD: begin
                memSignal[MEM_RD] = 1'b1;
                respValid_d       = 1'b1;
                respRdata_d       = loadData;
                state_d           = IDLE;
            end
            RMW_RD: begin
                memSignal[MEM_RD] = 1'b1;
                memData_d         = storeData;
                state_d           = WR;
            end
            WR: begin
                memSignal[MEM_WR] = 1'b1;
                respValid_d       = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            reqOffset_q   <= '0;
            reqSize_q     <= '0;
            reqUnsigned_q <= 1'b0;
            reqWdata_q    <= '0;
            memAddr_q     <= '0;
            memData_q     <= '0;
            respValid_q   <= 1'b0;
            respErr_q     <= 1'b0;
            respRdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
            respValid_q <= respValid_d;
            respErr_q   <= respErr_d;
            respRdata_q <= respRdata_d;
            if (accept) begin
                reqOffset_q   <= req_addr_i[1:0];
                reqSize_q     <= req_size_i;
                reqUnsigned_q <= req_unsigned_i;
                reqWdata_q    <= req_wdata_i;
            end
        end
    end

    assign mem_signal_o = memSignal;
    assign mem_addr_o   = memAddr_q;
    assign mem_data_o   = memData_q;
    assign resp_valid_o = respValid_q;
    assign err_o        = respErr_q;
    assign resp_rdata_o = respRdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-addressed reference memory
// predicts every response; a monitor compares responses as they appear.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [2:0]  mem_signal_o;
    logic [31:0] mem_data_i = 32'h0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .err_o          (err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_signal_o   (mem_signal_o),
        .mem_data_i     (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nWr;
        int          nRd;
        logic        chkWord;
        logic [31:0] wordAddr;
        logic [31:0] word;
        int          acceptCyc;
        int          wrBase;
        int          rdBase;
    } exp_t;

    exp_t expQ[$];
    logic [7:0]  refBytes [logic [31:0]];
    logic [31:0] phys     [logic [31:0]];
    int cyc = 0;
    int writeCount = 0;
    int readCount = 0;
    int errors = 0;
    int checks = 0;

    // Untouched memory has a fixed, address-dependent pattern shared by the model and the memory.
    function automatic logic [7:0] initByte(input logic [31:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd29;
        return t ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return refBytes.exists(a) ? refBytes[a] : initByte(a);
    endfunction

    function automatic logic [31:0] physRead(input logic [31:0] wa);
        if (phys.exists(wa)) return phys[wa];
        return {initByte(wa + 32'd3), initByte(wa + 32'd2), initByte(wa + 32'd1), initByte(wa)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelRequest(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        int n;
        logic [31:0] val;
        n = 1 << size;
        e = '{default: '0};
        e.err = (size == 2'b11) || ((addr & 32'(n - 1)) != 32'd0);
        if (e.err) begin
            e.lat = 1;
        end else if (!we) begin
            val = 32'd0;
            for (int i = 0; i < n; i++) val |= 32'(refByte(addr + 32'(i))) << (8 * i);
            if (!uns && n < 4 && val[8 * n - 1]) val |= ~((32'd1 << (8 * n)) - 32'd1);
            e.rdata = val;
            e.lat   = 2;
            e.nRd   = 1;
        end else begin
            for (int i = 0; i < n; i++) refBytes[addr + 32'(i)] = 8'(wdata >> (8 * i));
            e.lat      = (n == 4) ? 2 : 3;
            e.nRd      = (n == 4) ? 0 : 1;
            e.nWr      = 1;
            e.chkWord  = 1'b1;
            e.wordAddr = addr & ~32'd3;
            for (int i = 0; i < 4; i++) e.word[8 * i +: 8] = refByte(e.wordAddr + 32'(i));
        end
    endtask

    always @(posedge clk_i) begin
        cyc++;
        if (mem_signal_o[0]) begin
            writeCount++;
            phys[mem_addr_o] = mem_data_o;
        end
        if (mem_signal_o[1]) readCount++;
    end

    always @(negedge clk_i) mem_data_i = physRead(mem_addr_o);

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && resp_valid_o) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("err", 32'(err_o), 32'(e.err));
                checkOutput("rdata", resp_rdata_o, e.rdata);
                checkOutput("latency", 32'(cyc - e.acceptCyc + 1), 32'(e.lat));
                checkOutput("write_cycles", 32'(writeCount - e.wrBase), 32'(e.nWr));
                checkOutput("read_cycles", 32'(readCount - e.rdBase), 32'(e.nRd));
                checkOutput("sig_bit2", 32'(mem_signal_o[2]), 32'd0);
                if (e.chkWord) checkOutput("mem_word", physRead(e.wordAddr), e.word);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, output int waited);
        exp_t e;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_valid_i    = 1'b1;
        waited         = 0;
        while (!req_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        if (!req_ready_o) begin
            checkOutput("ready_timeout", 32'(req_ready_o), 32'd1);
            req_valid_i = 1'b0;
            return;
        end
        modelRequest(we, size, uns, addr, wdata, e);
        e.acceptCyc = cyc + 1;
        e.wrBase    = writeCount;
        e.rdBase    = readCount;
        expQ.push_back(e);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic resetDuringWrite();
        int wrBase;
        repeat (4) @(negedge clk_i);
        req_we_i       = 1'b1;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h9;
        req_wdata_i    = 32'h0000_0077;
        req_valid_i    = 1'b1;
        checkOutput("rst_ready_pre", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst_wr_state", 32'(mem_signal_o), 32'd1);
        wrBase = writeCount;
        rst_i  = 1'b1;
        #1;
        checkOutput("rst_sig_drop", 32'(mem_signal_o), 32'd0);
        checkOutput("rst_no_resp", 32'(resp_valid_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("rst_no_write", 32'(writeCount - wrBase), 32'd0);
        checkOutput("rst_ready_post", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        logic [31:0] bases [3];
        bases = '{32'h0000_0000, 32'h0000_1000, 32'hFFFF_FFE0};
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_size_i = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i = 32'h0;
        req_wdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_ready", 32'(req_ready_o), 32'd1);
        checkOutput("reset_resp_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("reset_err", 32'(err_o), 32'd0);
        checkOutput("reset_rdata", resp_rdata_o, 32'd0);
        checkOutput("reset_mem_signal", 32'(mem_signal_o), 32'd0);
        checkOutput("reset_mem_addr", mem_addr_o, 32'd0);
        checkOutput("reset_mem_data", mem_data_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, w);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, w);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0055, w);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, w);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, w);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, w);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, w);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_8001, w);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, w);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, w);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, w);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, w);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h3, 32'h1234, w);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, w);

        resetDuringWrite();
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, w);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AA, w);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, w);
        checkOutput("hold_wait_cycles", 32'(w), 32'd2);

        for (int k = 0; k < 300; k++) begin
            logic [1:0] sz;
            logic [31:0] addr;
            int r;
            r    = $urandom_range(0, 15);
            sz   = (r == 0) ? 2'b11 : 2'(r % 3);
            addr = bases[$urandom_range(0, 2)] | 32'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end

        for (int t = 0; t < 20 && expQ.size() != 0; t++) @(negedge clk_i);
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
